// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: state encodings, stall causes and register-zero constant for pipeline_controller
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_LOAD_STALL = 2'd1,
    S_FLUSH      = 2'd2,
    S_MEM_WAIT   = 2'd3
  } state_e;
  typedef enum logic [1:0] {
    C_NONE   = 2'd0,
    C_MEM    = 2'd1,
    C_BRANCH = 2'd2,
    C_LOAD   = 2'd3
  } cause_e;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags a load in EX whose non-zero destination is read by the instruction in ID
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  output logic       hazard
);
  assign hazard = ex_mem_read & (ex_rt != REG_ZERO) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
endmodule

// File: rtl/pipeline_controller.sv
// pipeline_controller: 5-stage hazard/stall/flush control; `PIPE_CTRL_PERF_EN adds stall_cycles/flush_events counters
module pipeline_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic       mem_branch_taken,
  input  logic       mem_access,
  input  logic       mem_ready,
  output logic       pc_write_en,
  output logic       pc_sel_branch,
  output logic       if_id_write_en,
  output logic       id_ex_write_en,
  output logic       ex_mem_write_en,
  output logic       mem_wb_write_en,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       ex_mem_flush,
  output logic       mem_wb_flush,
  output logic [1:0] ctrl_state,
  output logic       mem_timeout
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);
  localparam logic [7:0] MW = 8'(MAX_WAIT);
  state_e state_q, state_d;
  cause_e cause;
  logic [7:0] wait_q, wait_d;
  logic timeout_q, timeout_d;
  logic hazard, hold;
  load_use_detect u_lud (
    .ex_mem_read(ex_mem_read),
    .ex_rt      (ex_rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .hazard     (hazard)
  );
  assign hold = (state_q == S_MEM_WAIT) ? !mem_ready : mem_access & !mem_ready;
  always_comb begin
    state_d   = S_RUN;
    wait_d    = '0;
    timeout_d = timeout_q;
    cause     = C_NONE;
    if (hold) begin
      cause     = C_MEM;
      state_d   = S_MEM_WAIT;
      wait_d    = (state_q != S_MEM_WAIT) ? 8'd1 : (wait_q == 8'hff) ? wait_q : wait_q + 8'd1;
      timeout_d = timeout_q | ((state_q == S_MEM_WAIT) & (wait_q == MW));
    end else if (mem_branch_taken & (state_q != S_FLUSH)) begin
      cause   = C_BRANCH;
      state_d = S_FLUSH;
    end else if (hazard & (state_q != S_LOAD_STALL)) begin
      cause   = C_LOAD;
      state_d = S_LOAD_STALL;
    end
  end
  assign pc_write_en     = !(rst | (cause == C_MEM) | (cause == C_LOAD));
  assign if_id_write_en  = pc_write_en;
  assign id_ex_write_en  = !(rst | (cause == C_MEM));
  assign ex_mem_write_en = id_ex_write_en;
  assign mem_wb_write_en = !rst;
  assign if_id_flush     = rst | (cause == C_BRANCH);
  assign id_ex_flush     = rst | (cause == C_BRANCH) | (cause == C_LOAD);
  assign ex_mem_flush    = if_id_flush;
  assign mem_wb_flush    = rst | (cause == C_MEM);
  assign pc_sel_branch   = !rst & (cause == C_BRANCH);
  assign ctrl_state      = state_q;
  assign mem_timeout     = timeout_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_q, flush_q;
  always_ff @(posedge clk) begin
    stall_q <= rst ? '0 : stall_q + {31'd0, !pc_write_en};
    flush_q <= rst ? '0 : flush_q + {31'd0, cause == C_BRANCH};
  end
  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`endif
endmodule

// File: tb/tb_pipeline_controller.sv
// tb_pipeline_controller: directed vectors with a scoreboard queue checked by a negedge monitor
module tb_pipeline_controller;
  localparam int MW = 16;
  localparam logic [4:0] WE_ALL = 5'b11111, WE_LU = 5'b00111, WE_MEM = 5'b00001, WE_RST = 5'b00000;
  localparam logic [3:0] FL_NONE = 4'b0000, FL_LU = 4'b0100, FL_BR = 4'b1110, FL_MEM = 4'b0001, FL_RST = 4'b1111;
  typedef struct {
    string       name;
    logic [12:0] v;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic id_uses_rt = 1'b0, ex_mem_read = 1'b0, mem_branch_taken = 1'b0, mem_access = 1'b0, mem_ready = 1'b1;
  logic pc_write_en, pc_sel_branch, if_id_write_en, id_ex_write_en, ex_mem_write_en, mem_wb_write_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mem_timeout;
  logic [1:0] ctrl_state;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles, flush_events;
`endif
  exp_t sb[$];
  int vectors = 0, fails = 0;
  always #5 clk = ~clk;
  pipeline_controller #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken),
    .mem_access(mem_access), .mem_ready(mem_ready), .pc_write_en(pc_write_en),
    .pc_sel_branch(pc_sel_branch), .if_id_write_en(if_id_write_en), .id_ex_write_en(id_ex_write_en),
    .ex_mem_write_en(ex_mem_write_en), .mem_wb_write_en(mem_wb_write_en), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .ctrl_state(ctrl_state), .mem_timeout(mem_timeout)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );
  function automatic logic [12:0] ex(logic [4:0] we, logic [3:0] fl, logic sel, logic [1:0] st, logic to);
    return {we, fl, sel, st, to};
  endfunction
  task automatic step(string n, logic r, logic [4:0] rs, logic [4:0] rt, logic urt, logic mrd,
                      logic [4:0] ert, logic br, logic acc, logic rdy, logic [12:0] e);
    rst = r; id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_mem_read = mrd; ex_rt = ert;
    mem_branch_taken = br; mem_access = acc; mem_ready = rdy;
    sb.push_back('{n, e});
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [12:0] got;
      e = sb.pop_front();
      got = {pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en, mem_wb_write_en,
             if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, pc_sel_branch, ctrl_state, mem_timeout};
      vectors++;
      if (got !== e.v) begin
        fails++;
        $display("FAIL %s: got we=%b fl=%b sel=%b st=%0d to=%b, expected we=%b fl=%b sel=%b st=%0d to=%b",
                 e.name, got[12:8], got[7:4], got[3], got[2:1], got[0],
                 e.v[12:8], e.v[7:4], e.v[3], e.v[2:1], e.v[0]);
      end
    end
  end
  initial begin
    @(posedge clk);
    #1;
    step("reset", 1, 0, 0, 0, 0, 0, 0, 0, 1, ex(WE_RST, FL_RST, 0, 0, 0));
    step("idle", 0, 0, 0, 0, 0, 0, 0, 0, 1, ex(WE_ALL, FL_NONE, 0, 0, 0));
    step("lu_rs", 0, 5, 0, 0, 1, 5, 0, 0, 1, ex(WE_LU, FL_LU, 0, 0, 0));
    step("lu_rs_stalled", 0, 5, 0, 0, 1, 5, 0, 0, 1, ex(WE_ALL, FL_NONE, 0, 1, 0));
    step("lu_rs_back", 0, 0, 0, 0, 0, 0, 0, 0, 1, ex(WE_ALL, FL_NONE, 0, 0, 0));
    step("lu_zero", 0, 0, 0, 0, 1, 0, 0, 0, 1, ex(WE_ALL, FL_NONE, 0, 0, 0));
    step("lu_rt_unused", 0, 1, 5, 0, 1, 5, 0, 0, 1, ex(WE_ALL, FL_NONE, 0, 0, 0));
    step("lu_rt", 0, 1, 5, 1, 1, 5, 0, 0, 1, ex(WE_LU, FL_LU, 0, 0, 0));
    step("lu_rt_stalled", 0, 0, 0, 0, 0, 0, 0, 0, 1, ex(WE_ALL, FL_NONE, 0, 1, 0));
    step("lu_rt_back", 0, 0, 0, 0, 0, 0, 0, 0, 1, ex(WE_ALL, FL_NONE, 0, 0, 0));
    step("br_1", 0, 0, 0, 0, 0, 0, 1, 0, 1, ex(WE_ALL, FL_BR, 1, 0, 0));
    step("br_2", 0, 0, 0, 0, 0, 0, 1, 0, 1, ex(WE_ALL, FL_NONE, 0, 2, 0));
    step("br_back", 0, 0, 0, 0, 0, 0, 0, 0, 1, ex(WE_ALL, FL_NONE, 0, 0, 0));
    step("mw_1", 0, 0, 0, 0, 0, 0, 0, 1, 0, ex(WE_MEM, FL_MEM, 0, 0, 0));
    step("mw_2", 0, 0, 0, 0, 0, 0, 0, 1, 0, ex(WE_MEM, FL_MEM, 0, 3, 0));
    step("mw_3", 0, 0, 0, 0, 0, 0, 0, 1, 0, ex(WE_MEM, FL_MEM, 0, 3, 0));
    step("mw_release", 0, 0, 0, 0, 0, 0, 0, 1, 1, ex(WE_ALL, FL_NONE, 0, 3, 0));
    step("mw_back", 0, 0, 0, 0, 0, 0, 0, 0, 1, ex(WE_ALL, FL_NONE, 0, 0, 0));
    step("br_lu", 0, 5, 0, 0, 1, 5, 1, 0, 1, ex(WE_ALL, FL_BR, 1, 0, 0));
    step("flush_lu", 0, 5, 0, 0, 1, 5, 1, 0, 1, ex(WE_LU, FL_LU, 0, 2, 0));
    step("flush_lu_stalled", 0, 0, 0, 0, 0, 0, 0, 0, 1, ex(WE_ALL, FL_NONE, 0, 1, 0));
    step("flush_lu_back", 0, 0, 0, 0, 0, 0, 0, 0, 1, ex(WE_ALL, FL_NONE, 0, 0, 0));
    for (int i = 1; i <= MW + 2; i++)
      step($sformatf("to_wait_%0d", i), 0, 0, 0, 0, 0, 0, 0, 1, 0,
           ex(WE_MEM, FL_MEM, 0, (i == 1) ? 2'd0 : 2'd3, i == MW + 2));
    step("to_release", 0, 0, 0, 0, 0, 0, 0, 1, 1, ex(WE_ALL, FL_NONE, 0, 3, 1));
    step("to_sticky", 0, 0, 0, 0, 0, 0, 0, 0, 1, ex(WE_ALL, FL_NONE, 0, 0, 1));
    step("to_rst", 1, 0, 0, 0, 0, 0, 0, 0, 1, ex(WE_RST, FL_RST, 0, 0, 1));
    step("to_cleared", 0, 0, 0, 0, 0, 0, 0, 0, 1, ex(WE_ALL, FL_NONE, 0, 0, 0));
    step("mid_wait_enter", 0, 0, 0, 0, 0, 0, 0, 1, 0, ex(WE_MEM, FL_MEM, 0, 0, 0));
    step("mid_wait_rst", 1, 0, 0, 0, 0, 0, 0, 1, 0, ex(WE_RST, FL_RST, 0, 3, 0));
    step("mid_wait_after", 0, 0, 0, 0, 0, 0, 0, 0, 1, ex(WE_ALL, FL_NONE, 0, 0, 0));
    repeat (4) @(posedge clk);
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d vectors left unchecked, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
